// File: rtl/stack_drain.sv
// rtl/stack_drain.sv - pop-side sequencer draining up to count items from a LIFO stack
// Pops one word at a time, holds it on a valid/ready output, stops early if the stack empties.
module stack_drain #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CW-1:0]    count,
  input  logic             stk_empty,
  input  logic [WIDTH-1:0] stk_data,
  output logic             stk_pop,
  output logic             stk_push,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [CW-1:0]    drained
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    POP   = 3'd2,
    CAP   = 3'd3,
    OUT   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] remain;

  assign stk_push = 1'b0;

  // All outputs are registered; each is set on the edge that enters its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remain    <= '0;
      stk_pop   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      short     <= 1'b0;
      drained   <= '0;
    end else begin
      stk_pop <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            short   <= 1'b0;
            drained <= '0;
            busy    <= 1'b1;
            if (count == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              remain <= count;
              state  <= CHECK;
            end
          end
        end
        CHECK: begin
          if (remain == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (stk_empty) begin
            short <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            stk_pop <= 1'b1;
            state   <= POP;
          end
        end
        POP: begin
          remain <= remain - 1'b1;
          state  <= CAP;
        end
        CAP: begin
          // The stack presents the popped word one cycle after the pop edge.
          out_data  <= stk_data;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            drained   <= drained + 1'b1;
            state     <= CHECK;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_drain.sv
// tb/tb_stack_drain.sv - directed self-checking bench for stack_drain
// A small behavioural stack model feeds the DUT; monitors count pops and handshakes.
module tb_stack_drain;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CW-1:0]    count = '0;
  logic             stk_empty;
  logic [WIDTH-1:0] stk_data = '0;
  logic             stk_pop;
  logic             stk_push;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             short;
  logic [CW-1:0]    drained;

  logic             rdy = 1'b1;
  logic             tog_en = 1'b0;
  logic [1:0]       tcnt = '0;
  logic             tb_push = 1'b0;
  logic             tb_clr = 1'b0;
  logic [WIDTH-1:0] tb_din = '0;

  logic [WIDTH-1:0] mem [0:15];
  int               sp = 0;
  int               pop_cnt = 0;
  int               bad_pop = 0;
  int               hs_cnt = 0;
  int               unstable = 0;
  logic [WIDTH-1:0] got_mem [0:63];
  logic             held_v = 1'b0;
  logic [WIDTH-1:0] held_d = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign stk_empty = (sp == 0);
  assign out_ready = tog_en ? tcnt[1] : rdy;

  stack_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .stk_empty(stk_empty), .stk_data(stk_data), .stk_pop(stk_pop), .stk_push(stk_push),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .short(short), .drained(drained)
  );

  always @(negedge clk) tcnt <= tcnt + 2'd1;

  // Stack model: pop sampled on the edge, word visible the following cycle.
  always @(posedge clk) begin
    if (tb_clr) begin
      sp <= 0;
    end else if (tb_push) begin
      mem[sp] <= tb_din;
      sp <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_data <= mem[sp-1];
      sp <= sp - 1;
    end
    if (stk_pop) pop_cnt <= pop_cnt + 1;
    if (stk_pop && sp == 0) bad_pop <= bad_pop + 1;
    if (out_valid && out_ready) begin
      got_mem[hs_cnt[5:0]] <= out_data;
      hs_cnt <= hs_cnt + 1;
    end
    if (held_v && (!out_valid || out_data !== held_d)) unstable <= unstable + 1;
    held_v <= out_valid && !out_ready;
    held_d <= out_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_item(input int v);
    tb_push = 1'b1;
    tb_din = WIDTH'(v);
    @(negedge clk);
    tb_push = 1'b0;
  endtask

  task automatic clear_stack();
    tb_clr = 1'b1;
    @(negedge clk);
    tb_clr = 1'b0;
  endtask

  task automatic preload(input int n);
    clear_stack();
    for (int i = 1; i <= n; i++) push_item(i);
  endtask

  task automatic run(input int n, input int budget, output int cyc);
    bit found;
    found = 1'b0;
    cyc = 0;
    start = 1'b1;
    count = CW'(n);
    while (cyc < budget && !found) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) found = 1'b1;
    end
    if (!found) cyc = -1;
  endtask

  initial begin
    int cyc, b, p0, h0;
    bit seen;

    tb_clr = 1'b1;
    repeat (2) @(negedge clk);
    tb_clr = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pop", stk_pop, 0);
    chk("rst_done", done, 0);
    chk("rst_drained", drained, 0);
    chk("rst_short", short, 0);
    chk("rst_push", stk_push, 0);
    rst = 1'b0;
    @(negedge clk);

    // count=3 from a full stack
    preload(8);
    b = hs_cnt;
    run(3, 60, cyc);
    chk("c3_latency", cyc, 14);
    chk("c3_drained", drained, 3);
    chk("c3_short", short, 0);
    chk("c3_out0", got_mem[b], 8);
    chk("c3_out1", got_mem[b+1], 7);
    chk("c3_out2", got_mem[b+2], 6);
    chk("c3_left", sp, 5);
    @(negedge clk);
    chk("c3_idle", busy, 0);

    // count=8 drains the whole stack
    preload(8);
    b = hs_cnt;
    run(8, 100, cyc);
    chk("c8_latency", cyc, 34);
    chk("c8_drained", drained, 8);
    chk("c8_short", short, 0);
    chk("c8_empty", stk_empty, 1);
    for (int i = 0; i < 8; i++) chk("c8_out", got_mem[b+i], 8 - i);

    // short stack: 2 items, count=5
    clear_stack();
    push_item(4);
    push_item(9);
    b = hs_cnt;
    run(5, 60, cyc);
    chk("sh_latency", cyc, 10);
    chk("sh_drained", drained, 2);
    chk("sh_short", short, 1);
    chk("sh_out0", got_mem[b], 9);
    chk("sh_out1", got_mem[b+1], 4);
    chk("sh_badpop", bad_pop, 0);

    // back-pressure with out_ready toggling every 2 cycles
    preload(8);
    p0 = pop_cnt;
    h0 = hs_cnt;
    tog_en = 1'b1;
    run(5, 200, cyc);
    tog_en = 1'b0;
    chk("bp_finished", (cyc > 0), 1);
    chk("bp_pops", pop_cnt - p0, 5);
    chk("bp_hs", hs_cnt - h0, 5);
    chk("bp_stable", unstable, 0);
    chk("bp_drained", drained, 5);
    chk("bp_short", short, 0);
    for (int i = 0; i < 5; i++) chk("bp_out", got_mem[h0+i], 8 - i);

    // count=0, with a second start while busy
    @(negedge clk);
    p0 = pop_cnt;
    start = 1'b1;
    count = '0;
    @(negedge clk);
    chk("z_done", done, 1);
    chk("z_busy", busy, 1);
    count = CW'(3);
    @(negedge clk);
    start = 1'b0;
    chk("z_idle", busy, 0);
    chk("z_done_pulse", done, 0);
    repeat (5) @(negedge clk);
    chk("z_ignored", busy, 0);
    chk("z_pops", pop_cnt - p0, 0);
    chk("z_drained", drained, 0);

    // reset while holding 7 in OUT
    preload(7);
    rdy = 1'b0;
    start = 1'b1;
    count = CW'(3);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) seen = 1'b1;
    end
    chk("rs_valid_seen", seen, 1);
    chk("rs_hold", out_data, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rs_busy", busy, 0);
    chk("rs_valid", out_valid, 0);
    chk("rs_pop", stk_pop, 0);
    chk("rs_drained", drained, 0);
    chk("rs_data", out_data, 0);
    rdy = 1'b1;
    b = hs_cnt;
    run(1, 40, cyc);
    chk("rs_latency", cyc, 6);
    chk("rs_drained1", drained, 1);
    chk("rs_next", got_mem[b], 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stack_drain.md
# stack_drain

Pop-side sequencer for the `stack` block (LIFO, push/pop, full/empty).
- On a `start` command it pops up to `count` items from the stack, stopping early if the stack runs empty.
- Each popped word goes downstream on a valid/ready handshake, so items come out top-of-stack first.
- It sits between the stack's pop port and any consumer. It never asserts push.

## Interface
Parameters:
- `WIDTH`, 4, data word width; must match the stack's `WIDTH`.
- `DEPTH`, 8, stack depth; sets counter width `CW = $clog2(DEPTH+1)`.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  single-cycle command pulse; ignored while `busy`=1.
- `count`  in  CW  number of items to drain; sampled when `start` is accepted.
- `stk_empty`  in  1  stack `empty` flag.
- `stk_data`  in  WIDTH  stack `data_out`.
- `stk_pop`  out  1  stack `pop` strobe.
- `stk_push`  out  1  stack `push`; constant 0.
- `out_data`  out  WIDTH  popped word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the word.
- `busy`  out  1  a command is in progress.
- `done`  out  1  one-cycle completion pulse.
- `short`  out  1  the last command ended because the stack was empty; valid from `done` until the next `start`.
- `drained`  out  CW  number of items delivered by the last command; same validity as `short`.

## Operation
Stack port contract:
- The stack samples `pop` on a rising edge.
- The popped word is on `data_out` in the cycle after that edge.
- `empty` is updated at the same edge.

State machine:
- IDLE
  - `start`=1 with `count`=0: go to DONE with `drained`=0 and `short`=0.
  - `start`=1 with `count`>0: latch `count` into `remain`, clear `drained`, go to CHECK.
- CHECK
  - `remain`=0: go to DONE with `short`=0.
  - `stk_empty`=1: go to DONE with `short`=1.
  - Otherwise: go to POP.
- POP: `stk_pop`=1 for exactly one cycle, decrement `remain`, go to CAP.
- CAP: register `stk_data` into `out_data`, go to OUT.
- OUT
  - `out_valid`=1. `out_data` and `out_valid` hold stable until `out_ready`=1.
  - On the handshake cycle: increment `drained`, go to CHECK.
- DONE: `done`=1 for one cycle, go to IDLE.

Output rules:
- `busy`=1 in every state except IDLE.
- `stk_pop` is asserted only in POP. POP is entered only when `stk_empty`=0 was seen in CHECK, so the block never pops an empty stack.
- `stk_push` is always 0.

## Timing
- Reset (`rst`=1 at an edge) forces IDLE, from any state.
  - All outputs go to 0: `stk_pop`, `out_valid`, `out_data`, `busy`, `done`, `short`, `drained`.
  - `remain` is cleared.
  - Reset mid-command: an item already popped but not yet handed off is discarded. An in-flight `stk_pop` is deasserted from the next cycle.
- Latency with `out_ready` held at 1 (`start` at edge 0):
  - CHECK in cycle 1, `stk_pop` in cycle 2, capture in cycle 3.
  - `out_valid` in cycle 4; the handshake completes at the end of cycle 4.
  - Throughput is 4 cycles per item.
  - For N items popped from a non-empty stack, `done` falls in cycle 4N+2.
- Early stop: if `stk_empty`=1 in CHECK, `done` falls in the next cycle with `short`=1.
- Back-pressure: each cycle of `out_ready`=0 in OUT adds one cycle. No further pop is issued while a word is pending.
- `start` while `busy`=1 is dropped silently; it is not queued.
- `count` greater than `DEPTH` is legal; the command ends via `short`.

## Test plan
- Stack preloaded with 1..8 (8 on top), `count`=3, `out_ready`=1.
  - Outputs 8, 7, 6.
  - `done` with `drained`=3 and `short`=0; stack left holding 5..1.
- Same preload, `count`=8.
  - Outputs 8..1.
  - `stk_empty`=1 after the last pop; `done` with `drained`=8 and `short`=0.
- Stack holds 2 items (top 9, then 4), `count`=5.
  - Outputs 9, 4.
  - `done` with `drained`=2 and `short`=1; `stk_pop` is never asserted while `stk_empty`=1.
- `count`=5 with stack preloaded 1..8 and `out_ready` toggled 0/1 every 2 cycles.
  - `out_data` stays stable while `out_valid`=1 and `out_ready`=0.
  - Exactly 5 pops and 5 handshakes.
- `count`=0.
  - `done` one cycle after `start`, `drained`=0, no `stk_pop`.
  - A second `start` pulsed while `busy`=1 is ignored.
- `rst`=1 while in OUT holding value 7.
  - Next cycle: `busy`=0, `out_valid`=0, `stk_pop`=0, `drained`=0.
  - A new `start` with `count`=1 then pops the next item (6).
